// File: rtl/cpu_pkg.sv
// Shared EX-stage definitions: ALU op codes for the multi-cycle path and the sequencer state type.
// No logic of its own; helpers are pure decode functions.
// Imported by the EX-stage blocks that need to recognise MULT/MULTU/DIV/DIVU.
package cpu_pkg;

  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_HOLD
  } md_state_t;

  // True for the four ops that go through the multi-cycle sequencer
  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  // True for the multiplier-bound subset
  function automatic logic is_mul_op(input logic [5:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU);
  endfunction

  // True for the signed variants
  function automatic logic is_signed_op(input logic [5:0] op);
    return (op == ALU_MULT) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sched.sv
// Sequencer for MULT/MULTU/DIV/DIVU in EX: launches one mul/div op, stalls the pipe, returns {hi,lo}.
// Latency: multiply commits MUL_LAT+2 cycles after accept; divide waits for div_done, watchdog DIV_MAX cycles.
// Backpressure: result parks in HOLD (done=1) while pipe_hold is high; flush cancels in any state.
module muldiv_sched
  import cpu_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_MAX = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  ALUControl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        pipe_hold,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_signed,
  output logic        mul_start,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_abort,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        stall,
  output logic        done,
  output logic [63:0] hiloData,
  output logic        hiloWrite,
  output logic        div_err
);

  localparam int CW = $clog2(DIV_MAX + 1);
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_LIM  = CW'(DIV_MAX);

  md_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   op_a_q, op_a_d;
  logic [31:0]   op_b_q, op_b_d;
  logic          op_signed_q, op_signed_d;
  logic [63:0]   hilo_q, hilo_d;

  logic accept;
  logic wd_expire;

  // rst also gates accept so nothing launches in the reset cycle itself
  assign accept    = !rst && (state_q == MD_IDLE) && ex_valid && is_muldiv(ALUControl) && !flush;
  // Divider ran out of time; a done arriving in the same cycle still wins
  assign wd_expire = (state_q == MD_DIV) && !div_done && (cnt_q == DIV_LIM);

  // State register, counter, launch operands and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MD_IDLE;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_signed_q <= 1'b0;
      hilo_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_signed_q <= op_signed_d;
      hilo_q      <= hilo_d;
    end
  end

  // Next-state: flush always returns to IDLE and discards any in-flight result
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_signed_d = op_signed_q;
    hilo_d      = hilo_q;
    if (flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            op_a_d      = a;
            op_b_d      = b;
            op_signed_d = is_signed_op(ALUControl);
            if (is_mul_op(ALUControl)) begin
              state_d = MD_MUL;
              cnt_d   = MUL_INIT;
            end else begin
              state_d = MD_DIV;
              cnt_d   = '0;
            end
          end
        end
        MD_MUL: begin
          // cnt counts down to the cycle the pipelined product is valid
          if (cnt_q == '0) begin
            hilo_d  = mul_result;
            state_d = MD_HOLD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        MD_DIV: begin
          if (div_done) begin
            hilo_d  = {div_r, div_q};
            state_d = MD_HOLD;
            cnt_d   = '0;
          end else if (wd_expire) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        MD_HOLD: begin
          if (!pipe_hold) state_d = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // Outputs: strobes decoded from state; rst forces them low in the reset cycle
  always_comb begin
    stall     = 1'b0;
    mul_start = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;
    div_err   = 1'b0;
    done      = 1'b0;
    hiloWrite = 1'b0;
    if (!rst) begin
      stall     = accept || (state_q == MD_MUL) || (state_q == MD_DIV);
      mul_start = !flush && (state_q == MD_MUL) && (cnt_q == MUL_INIT);
      div_start = !flush && (state_q == MD_DIV) && (cnt_q == '0);
      div_abort = (state_q == MD_DIV) && (flush || wd_expire);
      div_err   = !flush && wd_expire;
      done      = (state_q == MD_HOLD);
      hiloWrite = (state_q == MD_HOLD) && !pipe_hold && !flush;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_signed = op_signed_q;
  assign hiloData  = hilo_q;

endmodule
